fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the single-cycle LEGv8 datapath. Holds the program counter, drives the 6-bit word address of the 64-word instruction ROM, and registers the returned instruction with its PC into a one-entry fetch register. Downstream logic consumes that register through a valid/ready handshake. Taken branches redirect the PC and flush the register, and a misaligned branch target latches a sticky fault.

## Interface
- N, default 64: PC and branch-target width.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  6  ROM word address; always equals pc[7:2] (combinational from the PC register).
- imem_q  input  32  ROM read data for imem_addr, valid in the same cycle (combinational ROM).
- redirect  input  1  taken branch/jump this cycle.
- target  input  N  new PC when redirect=1.
- out_ready  input  1  downstream accepts the fetch register this cycle.
- out_valid  output  1  fetch register holds a valid instruction.
- out_instr  output  32  registered instruction.
- out_pc  output  N  PC of out_instr.
- fault  output  1  sticky misaligned-target flag.
- fetch_count  output  32  number of instructions accepted downstream (wraps modulo 2^32).

## Operation
- State machine with two states:
  - RUN: normal fetch.
  - FAULT: terminal until reset.
- Internal pc register, N bits.
- accept = out_valid & out_ready. load = ~out_valid | out_ready.
- RUN, per cycle, highest priority first:
  1. redirect=1 with target[1:0]!=0: go to FAULT, set fault=1, clear out_valid; pc unchanged.
  2. redirect=1 with an aligned target: pc<=target, out_valid<=0 (flush). out_instr and out_pc keep their old values. This cycle's imem_q is discarded.
  3. redirect=0 and load=1: out_instr<=imem_q, out_pc<=pc, out_valid<=1, pc<=pc+4.
  4. Otherwise (stall, i.e. out_valid=1 and out_ready=0): pc and the fetch register hold.
- fetch_count increments on every accept, in any state, including the cycle a redirect flushes.
- FAULT: out_valid=0, pc frozen, redirect ignored. fetch_count still counts (no further accepts are possible).
- Arithmetic:
  - pc+4 wraps modulo 2^N.
  - imem_addr uses only pc[7:2], so PCs at or above 256 alias into the 64 ROM words.
  - Upper target bits are kept in pc and out_pc.

## Timing
- Reset values: pc=0, out_valid=0, out_instr=0, out_pc=0, fault=0, fetch_count=0, state=RUN. imem_addr=0 during and after reset.
- First instruction:
  - Reset deasserted before edge k: the edge-k update loads word 0.
  - out_valid=1 from that edge, with out_pc=0.
- Throughput: with out_ready held at 1, one instruction per cycle; out_pc advances by 4 each cycle.
- Redirect latency:
  - Redirect sampled at edge k: out_valid=0 after edge k.
  - The target instruction appears after edge k+1, with out_pc=target.
  - Redirect bubble is exactly one cycle.
- Stall:
  - out_ready=0 with out_valid=1: outputs are stable, no PC advance.
  - On release, the held entry is accepted and the next word loads on the same edge.
- Redirect and out_ready=1 in the same cycle: the current entry is accepted (counted), then flushed.
- Reset mid-operation: overrides everything, including FAULT and a concurrent redirect.

## Test plan
- **Reset and stream.** Bench ROM model returns imem_q={26'h0, imem_addr}. Hold reset 2 cycles, then out_ready=1 for 5 cycles.
  - out_pc sequence 0,4,8,12,16 with out_instr 0,1,2,3,4.
  - fetch_count=4 after the fifth edge.
- **Backpressure.** Drop out_ready for 3 cycles while out_pc=8.
  - out_pc=8 and out_instr=2 stay stable; imem_addr stays 3.
  - On release, the next entry is out_pc=12.
- **Aligned redirect.** Redirect=1, target=0x28 at out_pc=4.
  - One cycle with out_valid=0.
  - Next: out_pc=0x28, out_instr=10.
  - Then out_pc=0x2C.
- **Wrap/alias.** Redirect to target=0xFC, then stream.
  - out_instr=63 at out_pc=0xFC.
  - Then out_pc=0x100 with out_instr=0 (alias).
- **Misaligned target.** Redirect with target=0x22.
  - fault=1 and out_valid=0 from the next edge.
  - A later redirect to 0x0 is ignored.
  - Reset clears fault and restarts fetch at pc=0.
- **Simultaneous events.** Redirect with out_ready=1 and out_valid=1 in the same cycle: fetch_count increments by 1 and the flush bubble still occurs. Reset asserted in the same cycle as a redirect: all outputs go to their reset values.

Source files
------------

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, ROM word addressing and a one-entry
// fetch register drained through a valid/ready handshake, with redirect flush and fault.
module fetch_stage #(
  parameter int unsigned N = 64
) (
  input  logic          clk,
  input  logic          reset,
  output logic [5:0]    imem_addr,
  input  logic [31:0]   imem_q,
  input  logic          redirect,
  input  logic [N-1:0]  target,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [N-1:0]  out_pc,
  output logic          fault,
  output logic [31:0]   fetch_count
);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pc_q, pc_d;
  logic          valid_q, valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [N-1:0]  opc_q, opc_d;
  logic [31:0]   cnt_q, cnt_d;

  logic accept;
  logic load;

  assign accept = valid_q & out_ready;
  assign load   = ~valid_q | out_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q;

    // Accepts are counted before any flush takes the entry away.
    if (accept) begin
      cnt_d = cnt_q + 32'd1;
    end

    unique case (state_q)
      StRun: begin
        if (redirect && (target[1:0] != 2'b00)) begin
          state_d = StFault;
          valid_d = 1'b0;
        end else if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
        end else if (load) begin
          instr_d = imem_q;
          opc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + N'(4);
        end
      end
      StFault: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only pc[7:2] reaches the ROM, so higher PCs alias into the 64 words.
  assign imem_addr   = pc_q[7:2];
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign fault       = (state_q == StFault);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; ROM model returns the word address as the instruction.
module tb_fetch_stage;

  localparam int unsigned N = 64;

  logic          clk;
  logic          reset;
  logic [5:0]    imem_addr;
  logic [31:0]   imem_q;
  logic          redirect;
  logic [N-1:0]  target;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [N-1:0]  out_pc;
  logic          fault;
  logic [31:0]   fetch_count;

  int n_cmp;
  int n_bad;

  fetch_stage #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .redirect    (redirect),
    .target      (target),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  assign imem_q = {26'h0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_entry(input string tag, input logic v, input logic [63:0] pc,
                             input logic [31:0] ins);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'(v));
    check_eq({tag, ".pc"}, out_pc, pc);
    check_eq({tag, ".instr"}, 64'(out_instr), 64'(ins));
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    redirect  = 1'b0;
    target    = '0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    check_entry("rst", 1'b0, 64'h0, 32'h0);
    check_eq("rst.fault", 64'(fault), 64'h0);
    check_eq("rst.count", 64'(fetch_count), 64'h0);
    check_eq("rst.addr", 64'(imem_addr), 64'h0);

    // Stream
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_entry($sformatf("stream%0d", i), 1'b1, 64'(4 * i), 32'(i));
    end
    check_eq("stream.count", 64'(fetch_count), 64'd4);

    // Mid-operation reset, then stream up to out_pc=8
    reset = 1'b1;
    step();
    check_entry("rst2", 1'b0, 64'h0, 32'h0);
    check_eq("rst2.count", 64'(fetch_count), 64'h0);
    reset = 1'b0;
    step();
    step();
    step();
    check_entry("pre_bp", 1'b1, 64'h8, 32'h2);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_entry($sformatf("bp%0d", i), 1'b1, 64'h8, 32'h2);
      check_eq($sformatf("bp%0d.addr", i), 64'(imem_addr), 64'd3);
      check_eq($sformatf("bp%0d.count", i), 64'(fetch_count), 64'd2);
    end
    out_ready = 1'b1;
    step();
    check_entry("bp_rel", 1'b1, 64'hC, 32'h3);
    check_eq("bp_rel.count", 64'(fetch_count), 64'd3);

    // Aligned redirect with a concurrent accept
    redirect = 1'b1;
    target   = 64'h28;
    step();
    check_entry("redir.bubble", 1'b0, 64'hC, 32'h3);
    check_eq("redir.count", 64'(fetch_count), 64'd4);
    redirect = 1'b0;
    step();
    check_entry("redir.tgt", 1'b1, 64'h28, 32'd10);
    check_eq("redir.tgt.count", 64'(fetch_count), 64'd4);
    step();
    check_entry("redir.next", 1'b1, 64'h2C, 32'd11);

    // Alias past word 63
    redirect = 1'b1;
    target   = 64'hFC;
    step();
    check_eq("alias.bubble", 64'(out_valid), 64'h0);
    redirect = 1'b0;
    step();
    check_entry("alias.fc", 1'b1, 64'hFC, 32'd63);
    step();
    check_entry("alias.100", 1'b1, 64'h100, 32'd0);
    check_eq("alias.addr", 64'(imem_addr), 64'd1);
    check_eq("alias.count", 64'(fetch_count), 64'd7);

    // Misaligned target
    redirect = 1'b1;
    target   = 64'h22;
    step();
    check_eq("mis.fault", 64'(fault), 64'h1);
    check_eq("mis.valid", 64'(out_valid), 64'h0);
    check_eq("mis.addr", 64'(imem_addr), 64'd1);
    check_eq("mis.count", 64'(fetch_count), 64'd8);
    target = 64'h0;
    step();
    step();
    check_eq("flt.fault", 64'(fault), 64'h1);
    check_eq("flt.valid", 64'(out_valid), 64'h0);
    check_eq("flt.addr", 64'(imem_addr), 64'd1);
    check_eq("flt.pc", out_pc, 64'h100);

    // Reset together with a redirect clears the fault
    reset  = 1'b1;
    target = 64'h40;
    step();
    check_entry("rst3", 1'b0, 64'h0, 32'h0);
    check_eq("rst3.fault", 64'(fault), 64'h0);
    check_eq("rst3.count", 64'(fetch_count), 64'h0);
    check_eq("rst3.addr", 64'(imem_addr), 64'h0);
    reset    = 1'b0;
    redirect = 1'b0;
    step();
    check_entry("restart", 1'b1, 64'h0, 32'h0);

    // PC wraps modulo 2^N
    redirect = 1'b1;
    target   = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check_eq("wrap.bubble", 64'(out_valid), 64'h0);
    redirect = 1'b0;
    step();
    check_entry("wrap.top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'd63);
    step();
    check_entry("wrap.zero", 1'b1, 64'h0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
